axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
// - Shares one AXI4 read master port (ar*/r* channels) among NUM_REQ HLS kernel read masters.
// - Each requester issues whole bursts; bursts are granted round-robin, one outstanding burst at a time.
// - Sits between generated kernels and the memory-side AXI slave.
// - Write channels are out of scope; kernels keep driving aw*/w*/b* directly.
// PARAMETERS
// - NUM_REQ     2   number of requesters, 2..8
// - ADDR_WIDTH  16  AXI address width
// - DATA_WIDTH  32  AXI read data width
// - LEN_WIDTH   8   arlen width; burst length = arlen+1 beats
// PORTS
// - clk            in   1                  single clock, all logic on posedge
// - rst            in   1                  synchronous, active-low reset (0 = reset)
// - req_araddr     in   NUM_REQ*ADDR_WIDTH  per-requester burst address, requester i at slice i
// - req_arlen      in   NUM_REQ*LEN_WIDTH   per-requester burst length-1
// - req_arsize     in   NUM_REQ*3           per-requester beat size
// - req_arburst    in   NUM_REQ*2           per-requester burst type
// - req_arvalid    in   NUM_REQ             address-channel valid, one bit per requester
// - req_arready    out  NUM_REQ             address accepted; one-hot pulse
// - req_rdata      out  DATA_WIDTH          read data, broadcast to all requesters
// - req_rvalid     out  NUM_REQ             beat valid; set only for the granted requester
// - req_rready     in   NUM_REQ             beat ready, one bit per requester
// - m_araddr       out  ADDR_WIDTH          master address
// - m_arlen        out  LEN_WIDTH           master burst length-1
// - m_arsize       out  3                   master beat size
// - m_arburst      out  2                   master burst type
// - m_arvalid      out  1                   master address valid
// - m_arready      in   1                   master address ready
// - m_rdata        in   DATA_WIDTH          master read data
// - m_rvalid       in   1                   master beat valid
// - m_rready       out  1                   master beat ready
// - grant_id       out  $clog2(NUM_REQ)     index of the current or last granted requester
// - busy           out  1                   1 from grant until the last beat completes
// BEHAVIOUR
// - Reset (rst=0 at posedge): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0.
//   Outputs held 0 during reset: m_arvalid, m_rready, req_arready, req_rvalid, busy.
// - Reset mid-burst abandons the burst. The slave side is reset together with this block.
// - FSM states: IDLE, ADDR, DATA.
// - IDLE:
//   - If any req_arvalid is set, pick the first set bit searching from rr_ptr upward, wrapping.
//   - Register its ar fields and grant_id, then go to ADDR next cycle. busy=1 from ADDR onward.
//   - No grant while all req_arvalid are 0.
// - ADDR:
//   - m_arvalid=1; m_ar* are driven from the registered fields.
//   - Requester ar inputs are ignored after capture.
//   - req_arready[grant_id] = m_arready (combinational, same cycle). All other arready bits are 0.
//   - On m_arvalid & m_arready: beat_cnt <= arlen, go to DATA.
// - DATA:
//   - m_rready = req_rready[grant_id].
//   - req_rvalid[grant_id] = m_rvalid; all other rvalid bits are 0.
//   - req_rdata = m_rdata, combinational pass-through with zero added latency.
//   - On each m_rvalid & m_rready beat: if beat_cnt==0, go to IDLE, set rr_ptr <= grant_id+1
//     (wraps to 0 at NUM_REQ), busy <= 0. Otherwise beat_cnt <= beat_cnt-1.
// - Latency:
//   - Requester arvalid seen in IDLE at cycle N -> m_arvalid=1 at cycle N+1.
//   - Back-to-back bursts cost 1 idle cycle between the last beat and the next m_arvalid.
// - Boundary conditions:
//   - arlen=0: a single-beat burst.
//   - arlen=2^LEN_WIDTH-1: 256 beats; beat_cnt is LEN_WIDTH wide and never underflows.
//   - m_rvalid in IDLE or ADDR: m_rready=0, so no beat is consumed.
//   - Simultaneous requests: round-robin order.
//   - A requester re-asserting arvalid right after its own burst yields to others that are pending.
//   - Requester dropping arvalid before arready: protocol violation; the already-captured burst still completes.
// - Width rules: grant_id and rr_ptr are $clog2(NUM_REQ) bits; pointer increment wraps modulo NUM_REQ.
// STRUCTURE
// - Shared constants header axi_arb_defs: state encodings (IDLE=0, ADDR=1, DATA=2)
//   and burst encodings (BURST_FIXED=0, BURST_INCR=1, BURST_WRAP=2).
// - One sub-module rr_pick:
//   - Combinational. Inputs: request vector, start pointer.
//   - Outputs: found flag and index (mask-and-priority, two passes).
// - Top level holds the FSM, registered ar fields, beat_cnt and the r-channel mux.
// TESTING
// 1. Reset: rst=0 for 3 cycles with all req_arvalid=1.
//    -> all outputs 0, busy=0; first grant_id=0 one cycle after rst=1.
// 2. Single request: req0 araddr=16'h0040, arlen=3, m_arready=1, m_rvalid=1 constant.
//    -> m_arvalid in cycle 1, 4 beats routed to req0, busy drops after beat 4, req1 rvalid stays 0.
// 3. Contention: req0 and req1 both assert arvalid with arlen=0.
//    -> grant order 0,1,0,1; each m_araddr matches its requester; 1 idle cycle between bursts.
// 4. Backpressure: m_arready low for 5 cycles, then req_rready[grant] toggles 1,0,1.
//    -> m_ar* stable while waiting; beats counted only on rvalid&rready; no dropped or duplicated rdata.
// 5. Stray data: m_rvalid=1 while IDLE.
//    -> m_rready=0 and no req_rvalid set.
// 6. Long burst plus reset: arlen=8'hFF completes 256 beats.
//    -> busy clears. Then rst=0 at beat 10 of a new burst -> FSM is IDLE and outputs are 0 the next cycle.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared encodings for the AXI read-channel arbiter: FSM states and AXI burst types.
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above start, else wrap to the lowest set request.
module axi_rd_arbiter_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] masked;
    logic               hit_masked;
    logic               hit_any;
    logic [IDX_W-1:0]   idx_masked;
    logic [IDX_W-1:0]   idx_any;

    always_comb begin
        masked = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            masked[i] = req[i] && (IDX_W'(i) >= start);
        end
    end

    // Scanning downward leaves the lowest set index in each result.
    always_comb begin
        hit_masked = 1'b0;
        idx_masked = '0;
        hit_any    = 1'b0;
        idx_any    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (masked[i]) begin
                hit_masked = 1'b1;
                idx_masked = IDX_W'(i);
            end
            if (req[i]) begin
                hit_any = 1'b1;
                idx_any = IDX_W'(i);
            end
        end
    end

    assign found = hit_any;
    assign idx   = hit_masked ? idx_masked : idx_any;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master among NUM_REQ requesters, one whole burst at a time, granted round-robin.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_arlen,
    input  logic [NUM_REQ*3-1:0]          req_arsize,
    input  logic [NUM_REQ*2-1:0]          req_arburst,
    input  logic [NUM_REQ-1:0]            req_arvalid,
    output logic [NUM_REQ-1:0]            req_arready,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]            req_rvalid,
    input  logic [NUM_REQ-1:0]            req_rready,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [LEN_WIDTH-1:0]          m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [1:0]                    fsm_state
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0]     ONE_IDX  = 1;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = 1;

    arb_state_t state_q;
    arb_state_t state_d;

    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      grant_q;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;

    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LEN_WIDTH-1:0]  sel_len;
    logic [2:0]            sel_size;
    logic [1:0]            sel_burst;
    logic                  sel_rready;
    logic                  beat_fire;

    axi_rd_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_arvalid),
        .start (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        sel_addr   = '0;
        sel_len    = '0;
        sel_size   = '0;
        sel_burst  = '0;
        sel_rready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_addr  = req_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len   = req_arlen[i*LEN_WIDTH +: LEN_WIDTH];
                sel_size  = req_arsize[i*3 +: 3];
                sel_burst = req_arburst[i*2 +: 2];
            end
            if (grant_q == IDX_W'(i)) begin
                sel_rready = req_rready[i];
            end
        end
    end

    // Handshakes: a transfer happens on a cycle where valid and ready are both 1.
    // The slave's m_arready and m_rvalid are forwarded combinationally to the granted
    // requester only, so each address or beat is consumed exactly once on either side.
    assign beat_fire = (state_q == ST_DATA) && m_rvalid && sel_rready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_found) state_d = ST_ADDR;
            ST_ADDR: if (m_arready) state_d = ST_DATA;
            ST_DATA: if (beat_fire && (beat_cnt == '0)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr   <= '0;
            grant_q  <= '0;
            beat_cnt <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= BURST_INCR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        addr_q  <= sel_addr;
                        len_q   <= sel_len;
                        size_q  <= sel_size;
                        burst_q <= sel_burst;
                    end
                end
                ST_ADDR: begin
                    if (m_arready) beat_cnt <= len_q;
                end
                ST_DATA: begin
                    if (beat_fire) begin
                        if (beat_cnt == '0) begin
                            rr_ptr <= (grant_q == LAST_IDX) ? '0 : grant_q + ONE_IDX;
                        end else begin
                            beat_cnt <= beat_cnt - LEN_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are gated by rst so they read 0 from the very first reset cycle.
    always_comb begin
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        req_arready = '0;
        req_rvalid  = '0;
        busy        = 1'b0;
        if (rst) begin
            busy = (state_q == ST_ADDR) || (state_q == ST_DATA);
            case (state_q)
                ST_ADDR: begin
                    m_arvalid = 1'b1;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        req_arready[i] = (grant_q == IDX_W'(i)) && m_arready;
                    end
                end
                ST_DATA: begin
                    m_rready = sel_rready;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        req_rvalid[i] = (grant_q == IDX_W'(i)) && m_rvalid;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_rdata = m_rdata;
    assign m_araddr  = addr_q;
    assign m_arlen   = len_q;
    assign m_arsize  = size_q;
    assign m_arburst = burst_q;
    assign grant_id  = grant_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed phases plus randomized traffic against a burst-level model.
`timescale 1ns/1ps
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int IW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N*AW-1:0] req_araddr;
    logic [N*LW-1:0] req_arlen;
    logic [N*3-1:0]  req_arsize;
    logic [N*2-1:0]  req_arburst;
    logic [N-1:0]    req_arvalid;
    logic [N-1:0]    req_arready;
    logic [DW-1:0]   req_rdata;
    logic [N-1:0]    req_rvalid;
    logic [N-1:0]    req_rready;
    logic [AW-1:0]   m_araddr;
    logic [LW-1:0]   m_arlen;
    logic [2:0]      m_arsize;
    logic [1:0]      m_arburst;
    logic            m_arvalid;
    logic            m_arready;
    logic [DW-1:0]   m_rdata;
    logic            m_rvalid;
    logic            m_rready;
    logic [IW-1:0]   grant_id;
    logic            busy;
    logic [1:0]      fsm_state;

    axi_rd_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_araddr  (req_araddr),
        .req_arlen   (req_arlen),
        .req_arsize  (req_arsize),
        .req_arburst (req_arburst),
        .req_arvalid (req_arvalid),
        .req_arready (req_arready),
        .req_rdata   (req_rdata),
        .req_rvalid  (req_rvalid),
        .req_rready  (req_rready),
        .m_araddr    (m_araddr),
        .m_arlen     (m_arlen),
        .m_arsize    (m_arsize),
        .m_arburst   (m_arburst),
        .m_arvalid   (m_arvalid),
        .m_arready   (m_arready),
        .m_rdata     (m_rdata),
        .m_rvalid    (m_rvalid),
        .m_rready    (m_rready),
        .grant_id    (grant_id),
        .busy        (busy),
        .fsm_state   (fsm_state)
    );

    int n_vec = 0;
    int n_err = 0;

    // requester (kernel) side
    bit          pend[N];
    logic [AW-1:0] r_addr[N];
    logic [LW-1:0] r_len[N];
    logic [2:0]  r_size[N];
    logic [1:0]  r_burst[N];
    int          budget[N];

    // traffic knobs
    int p_arready = 100;
    int p_rvalid  = 100;
    int p_rready  = 100;
    int p_refill  = 0;
    int ar_hold   = 0;
    int max_len   = 3;
    bit stray     = 1'b0;
    bit scramble  = 1'b0;

    // burst-level reference model
    bit          act;
    bit          addr_done;
    int          a_id;
    int          ptr;
    int          last_gnt;
    int          left;
    logic [AW-1:0] a_addr;
    logic [LW-1:0] a_len;
    logic [2:0]  a_size;
    logic [1:0]  a_burst;

    // scoreboard and slave model
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] s_addr_q[$];
    logic [LW-1:0] s_len_q[$];
    int            s_beat;
    int            consumed;
    int            gnt_log[$];

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] addr, input int k);
        logic [15:0] kk;
        kk = 16'(k * 7 + 1);
        return {addr ^ 16'hC3A5, kk};
    endfunction

    function automatic bit busy_traffic();
        bit r;
        r = act;
        for (int i = 0; i < N; i++) r = r || pend[i] || (budget[i] > 0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, want, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic arm(input int i, input logic [AW-1:0] addr, input int len);
        pend[i]   = 1'b1;
        r_addr[i] = addr;
        r_len[i]  = LW'(len);
        r_size[i] = 3'($urandom_range(2, 0));
        case ($urandom_range(2, 0))
            0:       r_burst[i] = BURST_FIXED;
            1:       r_burst[i] = BURST_INCR;
            default: r_burst[i] = BURST_WRAP;
        endcase
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_arvalid[i]            = pend[i];
            req_araddr[i*AW +: AW]    = r_addr[i];
            req_arlen[i*LW +: LW]     = r_len[i];
            req_arsize[i*3 +: 3]      = r_size[i];
            req_arburst[i*2 +: 2]     = r_burst[i];
            req_rready[i]             = ($urandom_range(99, 0) < p_rready);
        end
        if (scramble && act && !addr_done) req_araddr[a_id*AW +: AW] = AW'($urandom);
        m_arready = (ar_hold > 0) ? 1'b0 : ($urandom_range(99, 0) < p_arready);
        if (s_addr_q.size() != 0) begin
            m_rvalid = ($urandom_range(99, 0) < p_rvalid);
            m_rdata  = beat_data(s_addr_q[0], s_beat);
        end else begin
            m_rvalid = stray;
            m_rdata  = $urandom;
        end
    endtask

    task automatic check();
        bit in_addr;
        bit in_data;
        logic [N-1:0] oh;
        in_addr = act && !addr_done;
        in_data = act && addr_done;
        oh = '0;
        if (act) oh[a_id] = 1'b1;
        chk("busy", busy, act);
        chk("m_arvalid", m_arvalid, in_addr);
        if (in_addr) begin
            chk("m_araddr", m_araddr, a_addr);
            chk("m_arlen", m_arlen, a_len);
            chk("m_arsize", m_arsize, a_size);
            chk("m_arburst", m_arburst, a_burst);
        end
        chk("req_arready", req_arready, (in_addr && m_arready) ? oh : '0);
        chk("m_rready", m_rready, in_data ? req_rready[a_id] : 1'b0);
        chk("req_rvalid", req_rvalid, (in_data && m_rvalid) ? oh : '0);
        chk("req_rdata", req_rdata, m_rdata);
        chk("grant_id", grant_id, last_gnt);
    endtask

    task automatic update();
        bit found;
        int c;
        // scoreboard: requester-side consumption
        for (int i = 0; i < N; i++) begin
            if (req_rvalid[i] && req_rready[i]) begin
                chk("sb_pending", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) chk("beat_data", req_rdata, exp_q.pop_front());
                consumed++;
            end
        end
        if (act && !addr_done && ar_hold > 0) ar_hold--;
        // model: whole-burst round robin
        if (!act) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                c = (ptr + k) % N;
                if (!found && pend[c]) begin
                    found = 1'b1;
                    a_id  = c;
                end
            end
            if (found) begin
                act       = 1'b1;
                addr_done = 1'b0;
                last_gnt  = a_id;
                a_addr    = r_addr[a_id];
                a_len     = r_len[a_id];
                a_size    = r_size[a_id];
                a_burst   = r_burst[a_id];
                left      = int'(a_len) + 1;
            end
        end else if (!addr_done) begin
            if (m_arready) begin
                addr_done = 1'b1;
                for (int k = 0; k <= int'(a_len); k++) exp_q.push_back(beat_data(a_addr, k));
            end
        end else if (m_rvalid && req_rready[a_id]) begin
            left--;
            if (left == 0) begin
                act = 1'b0;
                ptr = (a_id + 1) % N;
            end
        end
        // kernels and slave react to the bus
        for (int i = 0; i < N; i++) if (req_arready[i]) pend[i] = 1'b0;
        if (m_arvalid && m_arready) begin
            s_addr_q.push_back(m_araddr);
            s_len_q.push_back(m_arlen);
            gnt_log.push_back(int'(grant_id));
        end
        if (m_rvalid && m_rready && s_addr_q.size() > 0) begin
            if (s_beat == int'(s_len_q[0])) begin
                void'(s_addr_q.pop_front());
                void'(s_len_q.pop_front());
                s_beat = 0;
            end else begin
                s_beat++;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && budget[i] > 0 && $urandom_range(99, 0) < p_refill) begin
                budget[i]--;
                arm(i, AW'($urandom), $urandom_range(max_len, 0));
            end
        end
    endtask

    task automatic cycle();
        drive();
        #1;
        check();
        update();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (busy_traffic() && n < max_cycles) begin
            cycle();
            n++;
        end
        chk(tag, n < max_cycles, 1'b1);
    endtask

    task automatic do_reset(input bit all_valid);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req_arvalid = all_valid ? '1 : '0;
            req_rready  = '1;
            m_arready   = 1'b1;
            m_rvalid    = 1'b1;
            m_rdata     = $urandom;
            @(posedge clk);
            #1;
            chk("rst_m_arvalid", m_arvalid, 1'b0);
            chk("rst_m_rready", m_rready, 1'b0);
            chk("rst_req_arready", req_arready, '0);
            chk("rst_req_rvalid", req_rvalid, '0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_grant_id", grant_id, 0);
            chk("rst_fsm_idle", fsm_state, 2'd0);
        end
        act = 1'b0;
        addr_done = 1'b0;
        ptr = 0;
        last_gnt = 0;
        exp_q.delete();
        s_addr_q.delete();
        s_len_q.delete();
        s_beat = 0;
        for (int i = 0; i < N; i++) begin
            pend[i]   = 1'b0;
            budget[i] = 0;
        end
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int want_order[4];
        int start_cnt;
        int n;
        want_order = '{0, 1, 0, 1};
        req_araddr = '0; req_arlen = '0; req_arsize = '0; req_arburst = '0;
        req_arvalid = '0; req_rready = '0;
        m_arready = 1'b0; m_rdata = '0; m_rvalid = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; r_addr[i] = '0; r_len[i] = '0; r_size[i] = '0; r_burst[i] = '0; budget[i] = 0;
        end
        consumed = 0;
        s_beat = 0;

        // 1: reset with every requester asserting, first grant goes to requester 0
        do_reset(1'b1);
        for (int i = 0; i < N; i++) arm(i, AW'(16'h0100 * (i + 1)), 1);
        run_until_idle("t1_drain", 200);

        // 2: single four-beat burst from requester 0, slave always ready
        p_arready = 100; p_rvalid = 100; p_rready = 100;
        arm(0, 16'h0040, 3);
        run_until_idle("t2_drain", 100);

        // 3: contention between 0 and 1, single-beat bursts, each re-arms at once
        arm(2, 16'h2222, 0);
        run_until_idle("t3_prep", 50);
        gnt_log.delete();
        p_refill = 100; max_len = 0;
        arm(0, 16'hA000, 0);
        arm(1, 16'hB000, 0);
        budget[0] = 1;
        budget[1] = 1;
        run_until_idle("t3_drain", 100);
        chk("t3_grant_count", gnt_log.size(), 4);
        for (int k = 0; k < 4 && k < gnt_log.size(); k++) chk("t3_grant_order", gnt_log[k], want_order[k]);

        // 4: address backpressure, then random rready; requester address scrambled after capture
        p_refill = 0; ar_hold = 5; p_rready = 50; p_rvalid = 70; scramble = 1'b1;
        arm(1, 16'h1234, 5);
        run_until_idle("t4_drain", 200);
        scramble = 1'b0;

        // 5: stray read data while nothing is granted
        stray = 1'b1; p_rvalid = 100; p_rready = 100;
        for (int c = 0; c < 6; c++) cycle();

        // randomized traffic on all requesters
        for (int ph = 0; ph < 4; ph++) begin
            p_arready = $urandom_range(100, 30);
            p_rvalid  = $urandom_range(100, 30);
            p_rready  = $urandom_range(100, 30);
            p_refill  = $urandom_range(80, 20);
            max_len   = (ph == 3) ? 15 : 7;
            for (int i = 0; i < N; i++) budget[i] = $urandom_range(6, 3);
            run_until_idle("rand_drain", 3000);
        end
        p_refill = 0;

        // 6: maximum-length burst, then reset in the middle of another
        p_arready = 100; p_rvalid = 100; p_rready = 100;
        arm(1, 16'hBEEF, 255);
        run_until_idle("t6_long", 600);
        arm(0, 16'h0ABC, 255);
        start_cnt = consumed;
        n = 0;
        while (consumed - start_cnt < 10 && n < 100) begin
            cycle();
            n++;
        end
        chk("t6_reach_beat10", n < 100, 1'b1);
        do_reset(1'b0);
        stray = 1'b0;
        arm(2, 16'h7777, 2);
        run_until_idle("t6_recover", 50);

        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
